// File: rtl/npu_output_interface.sv
// -----------------------------------------------------------------------------
// npu_output_interface
//
// Return path from the NPU to the CPU. Signed fixed-point results (16 bits,
// FRAC_BITS fraction bits) are buffered in an output FIFO. Each word is then
// converted to a 32-bit signed integer or to an IEEE-754 single, as selected by
// a configuration word, and presented on a valid/ready port.
//
// Data path: FIFO storage -> S1 register (word + config latched at pop)
//            -> conversion -> output register.
//
// Ports
//   CLK                                in   clock, rising edge
//   npu_rst_n                          in   asynchronous active-low reset
//   npu_output_fifo_write_en           in   push npu_output_fifo_din
//   npu_output_fifo_din          [15:0] in   fixed-point result from the NPU
//   npu_output_fifo_full               out  FIFO storage holds FIFO_DEPTH words
//   npu_output_fifo_empty              out  FIFO storage empty (pipeline may hold data)
//   npu_output_fifo_count              out  words in FIFO storage
//   npu_output_overflow                out  sticky: a write was attempted while full
//   npu_output_interface_conf_data_en  in   load config register
//   npu_output_interface_conf_data[15:0] in [15]=1 float, 0 int; [14:0]=k
//   npu_output_data              [31:0] out  converted word
//   npu_output_data_valid              out  npu_output_data is valid
//   npu_output_data_ready              in   consumer accepts when valid & ready
// -----------------------------------------------------------------------------
module npu_output_interface #(
   parameter int FIFO_DEPTH = 16,
   parameter int FRAC_BITS  = 7
) (
   input  logic                          CLK,
   input  logic                          npu_rst_n,
   input  logic                          npu_output_fifo_write_en,
   input  logic [15:0]                   npu_output_fifo_din,
   output logic                          npu_output_fifo_full,
   output logic                          npu_output_fifo_empty,
   output logic [$clog2(FIFO_DEPTH):0]   npu_output_fifo_count,
   output logic                          npu_output_overflow,
   input  logic                          npu_output_interface_conf_data_en,
   input  logic [15:0]                   npu_output_interface_conf_data,
   output logic [31:0]                   npu_output_data,
   output logic                          npu_output_data_valid,
   input  logic                          npu_output_data_ready
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   // FIFO storage and state
   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [15:0]   r_conf;

   // S1 stage: word plus the config that was current when it was popped
   logic          r_s1_valid;
   logic [15:0]   r_s1_data;
   logic [15:0]   r_s1_conf;

   // Output stage
   logic          r_out_valid;
   logic [31:0]   r_out_data;

   logic          w_full;
   logic          w_empty;
   logic          w_wr_acc;
   logic          w_out_load;
   logic          w_s1_adv;
   logic          w_pop;
   logic [31:0]   w_conv;

   // Full is taken from the registered count, so a write is refused when full
   // even if a pop happens on the same edge.
   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_wr_acc   = npu_output_fifo_write_en & ~w_full;
   assign w_out_load = ~r_out_valid | npu_output_data_ready;
   assign w_s1_adv   = ~r_s1_valid | w_out_load;
   assign w_pop      = ~w_empty & w_s1_adv;

   // Storage array has no reset; it is only ever read through the pointers.
   always_ff @(posedge CLK) begin
      if (w_wr_acc) begin
         r_mem[r_wr_ptr] <= npu_output_fifo_din;
      end
   end

   always_ff @(posedge CLK or negedge npu_rst_n) begin
      if (!npu_rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_conf     <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_wr_acc) - CW'(w_pop);
         if (npu_output_fifo_write_en && w_full) begin
            r_overflow <= 1'b1;
         end
         if (npu_output_interface_conf_data_en) begin
            r_conf <= npu_output_interface_conf_data;
         end
      end
   end

   // Pipeline registers. A word popped on the same edge as a config write
   // captures the old config, since r_conf updates only after that edge.
   always_ff @(posedge CLK or negedge npu_rst_n) begin
      if (!npu_rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_s1_conf   <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s1_valid <= w_pop;
            if (w_pop) begin
               r_s1_data <= r_mem[r_rd_ptr];
               r_s1_conf <= r_conf;
            end
         end
         if (w_out_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_data <= w_conv;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Conversion of the S1 word
   // ---------------------------------------------------------------------------
   logic [14:0] w_k;
   logic [31:0] w_x;
   logic [4:0]  w_lsh;
   logic [4:0]  w_rsh;
   logic [31:0] w_int;
   logic [16:0] w_sx;
   logic [16:0] w_abs;
   logic [4:0]  w_lead;
   logic [16:0] w_frac_low;
   logic [22:0] w_mant;
   logic [17:0] w_exp;
   logic [31:0] w_flt;

   always_comb begin
      w_k   = r_s1_conf[14:0];
      w_x   = {{16{r_s1_data[15]}}, r_s1_data};
      w_lsh = 5'(w_k - 15'(FRAC_BITS));
      w_rsh = 5'(15'(FRAC_BITS) - w_k);
      w_int = '0;
      if (w_k <= 15'd23) begin
         if (w_k >= 15'(FRAC_BITS)) begin
            w_int = w_x << w_lsh;
         end else begin
            w_int = $signed(w_x) >>> w_rsh;
         end
      end
   end

   always_comb begin
      // 17-bit magnitude so that -32768 is representable
      w_sx  = {r_s1_data[15], r_s1_data};
      w_abs = r_s1_data[15] ? (~w_sx + 17'd1) : w_sx;

      w_lead = '0;
      for (int i = 0; i < 17; i++) begin
         if (w_abs[i]) begin
            w_lead = 5'(i);
         end
      end

      // Drop the hidden one, then left-align the remaining bits in 23 bits.
      w_frac_low = w_abs & ~(17'd1 << w_lead);
      w_mant     = {6'b0, w_frac_low} << (5'd23 - w_lead);

      // Biased exponent in 18-bit two's complement: 127 + p - F - k
      w_exp = 18'd127 + 18'(w_lead) - 18'(FRAC_BITS) - 18'(w_k);

      w_flt = '0;
      if (r_s1_data != 16'h0000) begin
         if (w_exp[17] || (w_exp == '0)) begin
            w_flt = {r_s1_data[15], 31'b0};
         end else begin
            w_flt = {r_s1_data[15], w_exp[7:0], w_mant};
         end
      end
   end

   assign w_conv = r_s1_conf[15] ? w_flt : w_int;

   assign npu_output_fifo_full  = w_full;
   assign npu_output_fifo_empty = w_empty;
   assign npu_output_fifo_count = r_count;
   assign npu_output_overflow   = r_overflow;
   assign npu_output_data       = r_out_data;
   assign npu_output_data_valid = r_out_valid;

endmodule

// File: tb/tb_npu_output_interface.sv
// -----------------------------------------------------------------------------
// Testbench for npu_output_interface: directed vectors with hand-computed
// expected words pushed into a scoreboard queue; a monitor pops and compares
// every accepted output transfer.
// -----------------------------------------------------------------------------
module tb_npu_output_interface;

   logic        CLK = 1'b0;
   logic        npu_rst_n;
   logic        wr_en;
   logic [15:0] din;
   logic        fifo_full;
   logic        fifo_empty;
   logic [4:0]  fifo_count;
   logic        overflow;
   logic        conf_en;
   logic [15:0] conf_data;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;
   logic [31:0] sb_q[$];

   always #5 CLK = ~CLK;

   npu_output_interface #(.FIFO_DEPTH(16), .FRAC_BITS(7)) dut (
      .CLK                               (CLK),
      .npu_rst_n                         (npu_rst_n),
      .npu_output_fifo_write_en          (wr_en),
      .npu_output_fifo_din               (din),
      .npu_output_fifo_full              (fifo_full),
      .npu_output_fifo_empty             (fifo_empty),
      .npu_output_fifo_count             (fifo_count),
      .npu_output_overflow               (overflow),
      .npu_output_interface_conf_data_en (conf_en),
      .npu_output_interface_conf_data    (conf_data),
      .npu_output_data                   (out_data),
      .npu_output_data_valid             (out_valid),
      .npu_output_data_ready             (out_ready)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: valid & ready seen at the falling edge means a transfer on the
   // next rising edge (inputs only change just after rising edges).
   always @(negedge CLK) begin
      if (npu_rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h expected none", out_data);
         end else begin
            logic [31:0] e;
            e = sb_q.pop_front();
            $display("xfer t=%0t data=%h exp=%h", $time, out_data, e);
            chk("out_data", out_data, e);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [15:0] d, input logic [31:0] e, input bit acc);
      wr_en = 1'b1;
      din   = d;
      if (acc) sb_q.push_back(e);
      @(posedge CLK);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic cfg(input logic [15:0] c);
      conf_en   = 1'b1;
      conf_data = c;
      @(posedge CLK);
      #1;
      conf_en = 1'b0;
   endtask

   task automatic cw(input logic [15:0] c, input logic [15:0] d, input logic [31:0] e);
      cfg(c);
      wr(d, e, 1'b1);
      idle(2);
   endtask

   initial begin
      logic [15:0] d;
      int guard;
      npu_rst_n = 1'b0;
      wr_en     = 1'b0;
      din       = '0;
      conf_en   = 1'b0;
      conf_data = '0;
      out_ready = 1'b0;

      // Reset values
      idle(3);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_empty", 32'(fifo_empty), 32'd1);
      chk("rst_full", 32'(fifo_full), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      npu_rst_n = 1'b1;
      idle(5);
      chk("idle_valid", 32'(out_valid), 32'd0);

      // Int mode with latency check
      out_ready = 1'b1;
      cfg(16'h0007);
      wr(16'hFF80, 32'hFFFFFF80, 1'b1);
      chk("lat_e0_valid", 32'(out_valid), 32'd0);
      idle(1);
      chk("lat_e1_valid", 32'(out_valid), 32'd0);
      idle(1);
      chk("lat_e2_valid", 32'(out_valid), 32'd1);
      idle(2);
      cw(16'h0000, 16'h0280, 32'h00000005);
      cw(16'h000A, 16'h0003, 32'h00000018);
      cw(16'h0018, 16'h1234, 32'h00000000);

      // Float mode
      cw(16'h8000, 16'h0080, 32'h3F800000);
      wr(16'hFF40, 32'hBFC00000, 1'b1);
      wr(16'h8000, 32'hC3800000, 1'b1);
      wr(16'h0000, 32'h00000000, 1'b1);
      idle(2);
      cw(16'h8001, 16'h0080, 32'h3F000000);
      cw(16'h80FF, 16'h0001, 32'h00000000);

      // Backpressure: 18 words fill S1, output reg and 16 FIFO entries
      cfg(16'h0007);
      out_ready = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         d = i[0] ? (16'h8000 | 16'(i)) : 16'(i * 16'h0101);
         wr(d, {{16{d[15]}}, d}, 1'b1);
      end
      chk("bp_full", 32'(fifo_full), 32'd1);
      chk("bp_count", 32'(fifo_count), 32'd16);
      chk("bp_overflow0", 32'(overflow), 32'd0);
      wr(16'h7777, 32'h0, 1'b0);
      chk("bp_overflow1", 32'(overflow), 32'd1);
      chk("bp_count_after_drop", 32'(fifo_count), 32'd16);
      out_ready = 1'b1;
      idle(17);
      chk("bp_valid_17", 32'(out_valid), 32'd1);
      idle(1);
      chk("bp_valid_18", 32'(out_valid), 32'd0);
      chk("bp_empty", 32'(fifo_empty), 32'd1);
      chk("bp_sb_drained", 32'(sb_q.size()), 32'd0);

      // Config change between two words: A as int, B as float
      cfg(16'h0007);
      wr(16'h0100, 32'h00000100, 1'b1);
      idle(1);
      cfg(16'h8000);
      wr(16'h0100, 32'h40000000, 1'b1);
      idle(4);

      // Async reset mid-stream
      out_ready = 1'b0;
      cfg(16'h0007);
      wr(16'h0011, 32'h00000011, 1'b1);
      wr(16'h0022, 32'h00000022, 1'b1);
      idle(3);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2;
      npu_rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_data", out_data, 32'd0);
      chk("async_rst_count", 32'(fifo_count), 32'd0);
      chk("async_rst_overflow", 32'(overflow), 32'd0);
      sb_q.delete();
      idle(2);
      npu_rst_n = 1'b1;
      out_ready = 1'b1;
      idle(6);
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      // Bounded drain of anything still expected
      guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(posedge CLK);
         guard++;
      end
      chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
